// File: rtl/fft_mdc_stage.sv
// Radix-2 MDC FFT stage: lower-lane delay, commutator, upper delay, butterfly, twiddle multiply.
// Latency: one registered cycle from an accepted sample to its butterfly result.
// Backpressure: none; in_valid=0 freezes all state and drops out_valid the next cycle.
module fft_mdc_stage #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 8,
    parameter int TW_WIDTH = 9,
    parameter int TW_FRAC  = 7,
    parameter int SCALE    = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        in_valid,
    input  logic [WIDTH-1:0]                            in_up_re,
    input  logic [WIDTH-1:0]                            in_up_im,
    input  logic [WIDTH-1:0]                            in_l_re,
    input  logic [WIDTH-1:0]                            in_l_im,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] tw_addr,
    input  logic [TW_WIDTH-1:0]                         tw_re,
    input  logic [TW_WIDTH-1:0]                         tw_im,
    output logic                                        out_valid,
    output logic                                        out_sof,
    output logic [WIDTH-1:0]                            out_up_re,
    output logic [WIDTH-1:0]                            out_up_im,
    output logic [WIDTH-1:0]                            out_l_re,
    output logic [WIDTH-1:0]                            out_l_im
);

    localparam int CW = $clog2(2 * DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = WIDTH + TW_WIDTH + 3;

    localparam logic [CW:0] FILL_FULL    = (CW + 1)'(2 * DEPTH);
    localparam logic [CW:0] FILL_LAST    = (CW + 1)'(2 * DEPTH - 1);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    localparam logic signed [PW-1:0] RND     = PW'(1) << (TW_FRAC - 1);
    localparam logic signed [WIDTH:0] ONE    = (WIDTH + 1)'(1);

    logic [CW-1:0] cnt;
    logic [CW:0]   fill;
    logic          acc;

    // Samples only advance state when no reset or flush competes with them
    assign acc = in_valid & rst_n & ~flush;

    logic signed [WIDTH-1:0] d1_re [DEPTH];
    logic signed [WIDTH-1:0] d1_im [DEPTH];
    logic signed [WIDTH-1:0] d2_re [DEPTH];
    logic signed [WIDTH-1:0] d2_im [DEPTH];
    logic signed [WIDTH-1:0] cu_re, cu_im, cl_re, cl_im;

    // Commutator: swap in_up with the delayed lower lane during the second half of the span
    always_comb begin
        cu_re = $signed(in_up_re);
        cu_im = $signed(in_up_im);
        cl_re = d1_re[DEPTH-1];
        cl_im = d1_im[DEPTH-1];
        if (cnt[CW-1]) begin
            cu_re = d1_re[DEPTH-1];
            cu_im = d1_im[DEPTH-1];
            cl_re = $signed(in_up_re);
            cl_im = $signed(in_up_im);
        end
    end

    // Delay lines shift once per accepted sample; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (acc) begin
            d1_re[0] <= $signed(in_l_re);
            d1_im[0] <= $signed(in_l_im);
            d2_re[0] <= cu_re;
            d2_im[0] <= cu_im;
            for (int i = 1; i < DEPTH; i++) begin
                d1_re[i] <= d1_re[i-1];
                d1_im[i] <= d1_im[i-1];
                d2_re[i] <= d2_re[i-1];
                d2_im[i] <= d2_im[i-1];
            end
        end
    end

    function automatic logic [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[WIDTH-1:0];
        else                  sat = v[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] upper(input logic signed [WIDTH:0] s);
        logic signed [WIDTH:0] r;
        r = (s + ONE) >>> 1;
        if (SCALE != 0) upper = r[WIDTH-1:0];
        else            upper = sat(PW'(s));
    endfunction

    logic signed [WIDTH:0]  sum_re, sum_im, dif_re, dif_im;
    logic signed [PW-1:0]   p_re, p_im, q_re, q_im;
    logic [WIDTH-1:0]       up_re_n, up_im_n, l_re_n, l_im_n;

    // Butterfly at one extra bit, then scale/saturate upper and twiddle-multiply lower
    always_comb begin
        sum_re  = (WIDTH + 1)'(d2_re[DEPTH-1]) + (WIDTH + 1)'(cl_re);
        sum_im  = (WIDTH + 1)'(d2_im[DEPTH-1]) + (WIDTH + 1)'(cl_im);
        dif_re  = (WIDTH + 1)'(d2_re[DEPTH-1]) - (WIDTH + 1)'(cl_re);
        dif_im  = (WIDTH + 1)'(d2_im[DEPTH-1]) - (WIDTH + 1)'(cl_im);
        p_re    = PW'(dif_re) * PW'($signed(tw_re)) - PW'(dif_im) * PW'($signed(tw_im));
        p_im    = PW'(dif_re) * PW'($signed(tw_im)) + PW'(dif_im) * PW'($signed(tw_re));
        q_re    = (p_re + RND) >>> TW_FRAC;
        q_im    = (p_im + RND) >>> TW_FRAC;
        up_re_n = upper(sum_re);
        up_im_n = upper(sum_im);
        l_re_n  = sat(q_re);
        l_im_n  = sat(q_im);
    end

    // Counter, fill tracking and registered outputs; reset beats flush beats data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_up_re <= '0;
            out_up_im <= '0;
            out_l_re  <= '0;
            out_l_im  <= '0;
        end else if (flush) begin
            cnt       <= '0;
            fill      <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            out_valid <= in_valid && (fill >= FILL_LAST);
            out_sof   <= in_valid && (fill >= FILL_LAST) && (cnt == '0);
            if (in_valid) begin
                cnt       <= cnt + 1'b1;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
                out_up_re <= up_re_n;
                out_up_im <= up_im_n;
                out_l_re  <= l_re_n;
                out_l_im  <= l_im_n;
            end
        end
    end

    generate
        if (DEPTH > 1) begin : g_addr
            assign tw_addr = cnt[AW-1:0];
        end else begin : g_addr0
            assign tw_addr = 1'b0;
        end
    endgenerate

endmodule
